// File: rtl/uart_tx_feeder_pkg.sv
// uart_tx_feeder_pkg
// Shared definitions for the UART transmit feeder: the default FIFO depth and
// the one-hot launch-sequencer state encoding. The optional completion
// interrupt (macro UART_TX_FEEDER_IRQ_EN) needs no extra package content.
package uart_tx_feeder_pkg;

    localparam int DEPTH_DEFAULT = 16;

    // Bit positions of each state inside the one-hot state vector.
    localparam int S_IDLE_IDX      = 0;
    localparam int S_LOAD_IDX      = 1;
    localparam int S_LAUNCH_IDX    = 2;
    localparam int S_WAIT_ACT_IDX  = 3;
    localparam int S_WAIT_DONE_IDX = 4;

    typedef enum logic [4:0] {
        S_IDLE      = 5'(1 << S_IDLE_IDX),
        S_LOAD      = 5'(1 << S_LOAD_IDX),
        S_LAUNCH    = 5'(1 << S_LAUNCH_IDX),
        S_WAIT_ACT  = 5'(1 << S_WAIT_ACT_IDX),
        S_WAIT_DONE = 5'(1 << S_WAIT_DONE_IDX)
    } state_t;

endpackage

// File: rtl/uart_tx_feeder_fifo.sv
// uart_tx_feeder_fifo
// Byte FIFO for the UART transmit feeder. Pointers are one bit wider than the
// address so full and empty can be told apart; level, full and empty are
// registered so nothing downstream sees a combinational path from wr_en.
//
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   wr_en, wr_data       host write (dropped while full, sets overflow)
//   flush                empties the FIFO and clears overflow; beats wr_en/pop
//   pop                  advance the read pointer (ignored while empty)
//   rd_data              byte at the read pointer
//   full, empty, level   registered occupancy
//   overflow             sticky write-while-full flag
module uart_tx_feeder_fifo
    import uart_tx_feeder_pkg::*;
#(
    parameter  int DEPTH     = DEPTH_DEFAULT,
    localparam int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [7:0]           wr_data,
    input  logic                 flush,
    input  logic                 pop,
    output logic [7:0]           rd_data,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   level,
    output logic                 overflow
);

    logic [7:0]         mem [DEPTH];
    logic [ADDR_BITS:0] wr_ptr;
    logic [ADDR_BITS:0] rd_ptr;
    logic [ADDR_BITS:0] wr_ptr_nxt;
    logic [ADDR_BITS:0] rd_ptr_nxt;
    logic [ADDR_BITS:0] level_nxt;
    logic               do_wr;
    logic               do_pop;

    assign do_wr   = wr_en && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr[ADDR_BITS-1:0]];

    always_comb begin
        wr_ptr_nxt = wr_ptr + {{ADDR_BITS{1'b0}}, do_wr};
        rd_ptr_nxt = rd_ptr + {{ADDR_BITS{1'b0}}, do_pop};
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end
        level_nxt = wr_ptr_nxt - rd_ptr_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            level  <= level_nxt;
            full   <= (level_nxt == (ADDR_BITS+1)'(DEPTH));
            empty  <= (level_nxt == '0);
            if (flush)
                overflow <= 1'b0;
            else if (wr_en && full)
                overflow <= 1'b1;
        end
    end

    // Storage has no reset; only slots covered by the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr[ADDR_BITS-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
// Byte FIFO plus launch sequencer in front of a UART transmitter. Bytes are
// launched one at a time, each only once the transmitter reports idle, so the
// host can queue a burst and walk away.
//
// Optional build macro UART_TX_FEEDER_IRQ_EN adds tx_done_irq, a one-cycle
// pulse when the last queued byte has finished on the line (not after a
// flush-induced drain).
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   wr_en, wr_data        host byte write
//   flush                 discard queued bytes (single-cycle strobe)
//   full, empty, level    FIFO occupancy
//   overflow              sticky write-while-full flag
//   busy                  sequencer active or bytes pending
//   tx_active             transmitter shifting a frame
//   start_TX              one-cycle launch pulse to the transmitter
//   SBUF_out              byte presented to the transmitter
//   tx_done_irq           (UART_TX_FEEDER_IRQ_EN only) queue drained on the line
//
// state       | meaning
// S_IDLE      | waiting for a byte and an idle transmitter
// S_LOAD      | pop head byte into SBUF_out
// S_LAUNCH    | start_TX high for this cycle
// S_WAIT_ACT  | waiting for the transmitter to raise tx_active
// S_WAIT_DONE | waiting for the frame on the line to finish
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter  int DEPTH     = DEPTH_DEFAULT,
    localparam int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [7:0]           wr_data,
    input  logic                 flush,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   level,
    output logic                 overflow,
    output logic                 busy,
    input  logic                 tx_active,
    output logic                 start_TX,
    output logic [7:0]           SBUF_out
`ifdef UART_TX_FEEDER_IRQ_EN
    ,
    output logic                 tx_done_irq
`endif
);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] rd_data;
    logic       pop;
    logic       have_data;

    assign pop = (state == S_LOAD);

    uart_tx_feeder_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .pop      (pop),
        .rd_data  (rd_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    // A byte being written this cycle into an empty FIFO counts as available:
    // it lands in memory at this edge, so S_LOAD can read it next cycle and
    // the first launch comes two cycles after the write.
    assign have_data = !empty || (wr_en && !full);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (have_data && !tx_active) state_nxt = S_LOAD;
            S_LOAD:      state_nxt = S_LAUNCH;
            S_LAUNCH:    state_nxt = S_WAIT_ACT;
            S_WAIT_ACT:  if (tx_active) state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (!tx_active) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
        // A frame already on the line is allowed to finish before restarting.
        if (flush)
            state_nxt = tx_active ? S_WAIT_DONE : S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            SBUF_out <= 8'h00;
        else if (state == S_LOAD && !flush)
            SBUF_out <= rd_data;
    end

    assign start_TX = state[S_LAUNCH_IDX] && !flush;
    assign busy     = !state[S_IDLE_IDX] || !empty;

`ifdef UART_TX_FEEDER_IRQ_EN
    // Remembers that the current drain was caused by a flush so its end is
    // not reported as a completed transfer; a fresh launch clears it.
    logic flushed;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flushed     <= 1'b0;
            tx_done_irq <= 1'b0;
        end else begin
            tx_done_irq <= (state == S_WAIT_DONE) && !tx_active && !flush
                           && empty && !flushed;
            if (flush)
                flushed <= 1'b1;
            else if (state == S_LOAD)
                flushed <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

    localparam int DEPTH  = 16;
    localparam int TX_LEN = 20;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       busy;
    logic       tx_active;
    logic       start_TX;
    logic [7:0] SBUF_out;
`ifdef UART_TX_FEEDER_IRQ_EN
    logic       tx_done_irq;
`endif

    logic       tx_m;
    logic       tx_hold;
    int         tx_cnt;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] sb [$];
    int         last_fall = 0;
    logic       gap_chk = 1'b0;
    logic       prev_tm = 1'b0;
    int         irq_cnt = 0;
    int         irq_cyc = 0;

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .flush     (flush),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .busy      (busy),
        .tx_active (tx_active),
        .start_TX  (start_TX),
        .SBUF_out  (SBUF_out)
`ifdef UART_TX_FEEDER_IRQ_EN
        ,
        .tx_done_irq (tx_done_irq)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: tx_active rises the cycle after start_TX, high TX_LEN cycles.
    assign tx_active = tx_m | tx_hold;
    always @(posedge clk) begin
        if (!reset_n) begin
            tx_m   <= 1'b0;
            tx_cnt <= 0;
        end else if (start_TX) begin
            tx_m   <= 1'b1;
            tx_cnt <= TX_LEN;
        end else if (tx_cnt > 1) begin
            tx_cnt <= tx_cnt - 1;
        end else begin
            tx_m   <= 1'b0;
            tx_cnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(busy == 1'b0 && tx_active == 1'b0 && sb.size() == 0) && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 3000), 32'd1);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                if (prev_tm && !tx_m) begin
                    last_fall = cyc;
                    gap_chk   = (sb.size() != 0);
                end
                if (start_TX) begin
                    check("start_while_tx_active", 32'(tx_active), 32'd0);
                    check("start_has_data", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0)
                        check("sbuf_data", 32'(SBUF_out), 32'(sb.pop_front()));
                    if (gap_chk)
                        check("gap_after_fall", 32'(cyc - last_fall), 32'd3);
                    gap_chk = 1'b0;
                end
`ifdef UART_TX_FEEDER_IRQ_EN
                if (tx_done_irq) begin
                    irq_cnt++;
                    irq_cyc = cyc;
                end
`endif
            end
            prev_tm = tx_m;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        flush   = 1'b0;
        tx_hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_start", 32'(start_TX), 32'd0);
        check("rst_sbuf", 32'(SBUF_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // 1: single byte latency
        wr_en = 1'b1; wr_data = 8'hA5; sb.push_back(8'hA5);
        tick();
        wr_en = 1'b0;
        check("t1_empty_n1", 32'(empty), 32'd0);
        check("t1_start_n1", 32'(start_TX), 32'd0);
        tick();
        check("t1_start_n2", 32'(start_TX), 32'd1);
        check("t1_sbuf_n2", 32'(SBUF_out), 32'hA5);
        check("t1_empty_n2", 32'(empty), 32'd1);
        tick();
        check("t1_start_n3", 32'(start_TX), 32'd0);
        wait_idle("t1_drain");

        // 2: back-to-back bytes, gap checked by the monitor
        for (int i = 1; i <= 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(i); sb.push_back(8'(i));
            tick();
        end
        wr_en = 1'b0;
        wait_idle("t2_drain");

        // 3: fill past full while the transmitter is held busy
        tx_hold = 1'b1;
        tick();
        for (int i = 0; i < DEPTH + 2; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            if (i < DEPTH) sb.push_back(8'(8'h10 + i));
            tick();
            if (i == DEPTH - 1) begin
                check("t3_full_at_depth", 32'(full), 32'd1);
                check("t3_level_at_depth", 32'(level), 32'(DEPTH));
                check("t3_no_overflow_yet", 32'(overflow), 32'd0);
            end
        end
        wr_en = 1'b0;
        check("t3_full", 32'(full), 32'd1);
        check("t3_level", 32'(level), 32'(DEPTH));
        check("t3_overflow", 32'(overflow), 32'd1);
        tx_hold = 1'b0;
        wait_idle("t3_drain");
        check("t3_overflow_sticky", 32'(overflow), 32'd1);

        // 4: flush during S_WAIT_DONE with 5 bytes queued
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h40 + i); sb.push_back(8'(8'h40 + i));
            tick();
        end
        wr_en = 1'b0;
        repeat (3) tick();
        check("t4_level_before", 32'(level), 32'd5);
        flush = 1'b1;
        sb.delete();
        tick();
        flush = 1'b0;
        check("t4_level_after", 32'(level), 32'd0);
        check("t4_overflow_after", 32'(overflow), 32'd0);
        check("t4_empty_after", 32'(empty), 32'd1);
        begin
            int n = 0;
            while (tx_active && n < 100) begin
                tick();
                n++;
            end
            check("t4_tx_fall", 32'(n < 100), 32'd1);
        end
        repeat (5) tick();
        check("t4_busy_idle", 32'(busy), 32'd0);
`ifdef UART_TX_FEEDER_IRQ_EN
        check("t4_no_irq_after_flush", 32'(irq_cnt), 32'd0);
`endif
        wr_en = 1'b1; wr_data = 8'h77; sb.push_back(8'h77);
        tick();
        wr_en = 1'b0;
        wait_idle("t4_relaunch");

        // 5: flush + write in the S_LAUNCH cycle
        wr_en = 1'b1; wr_data = 8'h5A; sb.push_back(8'h5A);
        tick();
        wr_en = 1'b0;
        tick();
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        sb.delete();
        #1;
        check("t5_start_suppressed", 32'(start_TX), 32'd0);
        tick();
        flush = 1'b0; wr_en = 1'b0;
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_level", 32'(level), 32'd0);
        repeat (5) tick();
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_tx_idle", 32'(tx_active), 32'd0);

`ifdef UART_TX_FEEDER_IRQ_EN
        // 6a: completion interrupt after two bytes
        irq_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h91 + i); sb.push_back(8'(8'h91 + i));
            tick();
        end
        wr_en = 1'b0;
        wait_idle("t6_irq_drain");
        repeat (3) tick();
        check("t6_irq_count", 32'(irq_cnt), 32'd1);
        check("t6_irq_timing", 32'(irq_cyc - last_fall), 32'd1);
`endif

        // 6b: reset mid-frame
        for (int i = 0; i < 2; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h81 + i); sb.push_back(8'(8'h81 + i));
            tick();
        end
        wr_en = 1'b0;
        begin
            int n = 0;
            while (!tx_active && n < 20) begin
                tick();
                n++;
            end
            check("t6_frame_started", 32'(n < 20), 32'd1);
        end
        repeat (2) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        sb.delete();
        check("t6_rst_start", 32'(start_TX), 32'd0);
        check("t6_rst_sbuf", 32'(SBUF_out), 32'd0);
        check("t6_rst_empty", 32'(empty), 32'd1);
        check("t6_rst_full", 32'(full), 32'd0);
        check("t6_rst_level", 32'(level), 32'd0);
        check("t6_rst_overflow", 32'(overflow), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
`ifdef UART_TX_FEEDER_IRQ_EN
        check("t6_rst_irq", 32'(tx_done_irq), 32'd0);
`endif
        repeat (5) tick();
        check("t6_post_rst_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
